fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Read-side consumer for the synchronous fifo: pops bytes via the fifo's rd_en/dout/empty interface and
//  serialises each as a UART 8N1 frame (LSB first) on serial_out. Sits between the TX fifo and the board pin.
//  Never pops an empty fifo; paced by a baud counter derived from CLOCK_FREQ/BAUD_RATE.
// PARAMETERS
//  CLOCK_FREQ    125_000_000  system clock in Hz
//  BAUD_RATE     115_200      line rate in bits/s
//  CLKS_PER_BIT  CLOCK_FREQ/BAUD_RATE (localparam, integer divide, must be >= 2)
// PORTS
//  clk          in   1   single system clock, all logic on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  tx_en        in   1   permit starting a new frame
//  fifo_empty   in   1   fifo empty flag
//  fifo_dout    in   8   fifo read data, valid the cycle after an rd_en edge
//  fifo_rd_en   out  1   pop request; high for exactly one cycle per byte
//  serial_out   out  1   UART line, idle high
//  busy         out  1   high from pop through end of stop bit
//  bytes_sent   out  16  count of completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst_n=0, async): serial_out=1, fifo_rd_en=0, busy=0, bytes_sent=0, state=IDLE, counters=0.
//  FSM: IDLE -> FETCH -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: fifo_rd_en = tx_en & ~fifo_empty (combinational from state); if asserted go FETCH next edge.
//  FETCH: one cycle; latch fifo_dout into 8-bit shift reg; busy=1; go START.
//  START: serial_out=0 for CLKS_PER_BIT cycles.  DATA: 8 bits LSB first, CLKS_PER_BIT cycles each,
//   bit index 0..7, exit after index 7.  STOP: serial_out=1 for CLKS_PER_BIT cycles; on last cycle
//   bytes_sent++ and go IDLE.
//  serial_out is registered (no glitches); baud counter restarts at 0 on every state entry.
//  Back-to-back: stop-bit end to next start-bit begin = 2 cycles (IDLE + FETCH); frame = 10*CLKS_PER_BIT+2.
//  fifo_rd_en never high while fifo_empty=1 or outside IDLE; one pop per frame, order preserved.
//  tx_en low: no new pop; a frame in progress always completes. tx_en is sampled only in IDLE.
//  rst_n asserted mid-frame: line returns high immediately; byte in shift reg is lost (not re-read).
//  fifo becoming empty mid-frame has no effect on the current frame.
// CONFIGURATION
//  `FIFO_UART_TX_PARITY_EN defined: PARITY state inserted after DATA, sends even parity (^byte) for
//   CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT+2.  Undefined: no PARITY state, strict 8N1.
// STRUCTURE
//  Package uart_pkg: state encoding localparams (IDLE..STOP, PARITY), FRAME_DATA_BITS=8, clog2 helper
//   for baud counter width.  Sub-module baud_tick: counter 0..CLKS_PER_BIT-1, clear input, tick
//   output on terminal count; FSM and shift register stay in fifo_uart_tx.
// TESTING  (sim params CLOCK_FREQ=1000, BAUD_RATE=100 -> CLKS_PER_BIT=10; fifo model w/ 1-cycle read)
//  1 Reset, fifo empty, tx_en=1 for 50 cycles -> serial_out=1, fifo_rd_en=0, busy=0, bytes_sent=0.
//  2 Push 0xA5 -> one rd_en pulse; line 0,1,0,1,0,0,1,0,1,1 each 10 cycles; bytes_sent=1; busy falls.
//  3 Push 0x00..0x07, tx_en=1 -> 8 frames in order, 2-cycle gap between frames, rd_en never when empty,
//    bytes_sent=8, fifo empty at end.
//  4 tx_en=0 with 3 bytes queued -> no rd_en for 100 cycles; raise then drop tx_en mid-frame 1 ->
//    frame 1 completes, no further pop, bytes_sent=1.
//  5 rst_n=0 during data bit 3 of 0x3C -> serial_out=1 same cycle, busy=0, bytes_sent=0; after release
//    next queued byte transmits correctly.
//  6 With FIFO_UART_TX_PARITY_EN, send 0x07 -> parity bit 1, stop follows, frame 112 cycles incl. gap.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, frame constants and width helper for fifo_uart_tx.
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int FRAME_DATA_BITS = 8;

    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/baud_tick.sv
// baud_tick: free-running 0..CLKS_PER_BIT-1 counter with synchronous clear, ticks on terminal count.
module baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int W = clog2(CLKS_PER_BIT);

    logic [W-1:0] r_cnt;

    assign o_tick = (r_cnt == W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= (i_clr || o_tick) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous fifo and sends them as UART 8N1 frames, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        serial_out,
    output logic        busy,
    output logic [15:0] bytes_sent
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = ST_PARITY;
`else
    localparam state_t AFTER_DATA = ST_STOP;
`endif

    state_t                     r_state, w_next;
    logic [FRAME_DATA_BITS-1:0] r_data;
    logic [2:0]                 r_idx, w_idx_next;
    logic [15:0]                r_sent;
    logic                       r_tx, w_tx_next, w_tick, w_clr;

    // Counter is held clear while idle and on every state change so each bit period starts fresh.
    assign w_clr = (r_state != w_next) || (r_state == ST_IDLE);

    baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_comb begin
        w_next     = r_state;
        fifo_rd_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                fifo_rd_en = rst_n & tx_en & ~fifo_empty;
                w_next     = fifo_rd_en ? ST_FETCH : ST_IDLE;
            end
            ST_FETCH:  w_next = ST_START;
            ST_START:  w_next = w_tick ? ST_DATA : ST_START;
            ST_DATA:   w_next = (w_tick && r_idx == 3'(FRAME_DATA_BITS - 1)) ? AFTER_DATA : ST_DATA;
            ST_PARITY: w_next = w_tick ? ST_STOP : ST_PARITY;
            ST_STOP:   w_next = w_tick ? ST_IDLE : ST_STOP;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Line level is derived from the next state so the registered output lines up with the state.
    assign w_idx_next = (r_state == ST_DATA) ? r_idx + 3'(w_tick) : 3'd0;
    assign w_tx_next  = (w_next == ST_START)  ? 1'b0 :
                        (w_next == ST_DATA)   ? r_data[w_idx_next] :
                        (w_next == ST_PARITY) ? ^r_data : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_idx   <= '0;
            r_data  <= '0;
            r_sent  <= '0;
        end else begin
            r_state <= w_next;
            r_tx    <= w_tx_next;
            r_idx   <= w_idx_next;
            if (r_state == ST_FETCH) r_data <= fifo_dout;
            if (r_state == ST_STOP && w_tick) r_sent <= r_sent + 16'd1;
        end
    end

    assign serial_out = r_tx;
    assign busy       = (r_state != ST_IDLE);
    assign bytes_sent = r_sent;
endmodule
